// File: rtl/axil_master_pkg.sv
// -----------------------------------------------------------------------------
// axil_master_pkg
// Shared types and constants for the AXI4-Lite register master.
//   wr_state_t / rd_state_t : write and read channel FSM states
//   RESP_*                  : AXI response codes
//   WSTRB_ALL, PROT_DEFAULT : fixed attributes driven on every transaction
// -----------------------------------------------------------------------------
package axil_master_pkg;

  typedef enum logic [1:0] {
    W_IDLE,
    W_ADDR,
    W_RESP
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_ADDR,
    R_DATA
  } rd_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [3:0] WSTRB_ALL    = 4'hF;
  localparam logic [2:0] PROT_DEFAULT = 3'b000;

  // Anything other than OKAY is treated as a failed transaction.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != RESP_OKAY;
  endfunction

endpackage

// File: rtl/axil_master_wr.sv
// -----------------------------------------------------------------------------
// axil_master_wr
// Write channel of the AXI4-Lite register master: accepts a one-cycle request,
// drives AW and W together, lets each drop on its own handshake, then waits
// for B.
// Ports:
//   clk_in, areset          : clock, synchronous active-high reset
//   req, addr, data         : request pulse with (already truncated) address/data
//   ready                   : high while the channel is idle
//   m_axi_aw*/w*/b*         : AXI4-Lite AW, W and B channel signals
// -----------------------------------------------------------------------------
module axil_master_wr
  import axil_master_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk_in,
  input  logic              areset,
  input  logic              req,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       data,
  output logic              ready,
  output logic [ADDR_W-1:0] m_axi_awaddr,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  output logic [31:0]       m_axi_wdata,
  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,
  input  logic              m_axi_bvalid,
  output logic              m_axi_bready
);

  wr_state_t state;

  // A channel counts as done once its valid is low or is being accepted now.
  logic aw_done, w_done;
  assign aw_done = !m_axi_awvalid || m_axi_awready;
  assign w_done  = !m_axi_wvalid  || m_axi_wready;

  always_ff @(posedge clk_in) begin
    if (areset) begin
      state         <= W_IDLE;
      ready         <= 1'b1;
      m_axi_awaddr  <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wdata   <= '0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
    end else begin
      case (state)
        W_IDLE: begin
          if (req) begin
            m_axi_awaddr  <= addr;
            m_axi_wdata   <= data;
            m_axi_awvalid <= 1'b1;
            m_axi_wvalid  <= 1'b1;
            ready         <= 1'b0;
            state         <= W_ADDR;
          end
        end
        W_ADDR: begin
          if (m_axi_awvalid && m_axi_awready) m_axi_awvalid <= 1'b0;
          if (m_axi_wvalid && m_axi_wready)   m_axi_wvalid  <= 1'b0;
          if (aw_done && w_done) begin
            m_axi_bready <= 1'b1;
            state        <= W_RESP;
          end
        end
        W_RESP: begin
          if (m_axi_bvalid) begin
            m_axi_bready <= 1'b0;
            ready        <= 1'b1;
            state        <= W_IDLE;
          end
        end
        default: begin
          state <= W_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/axil_reg_master.sv
// -----------------------------------------------------------------------------
// axil_reg_master
// Single-beat AXI4-Lite master executing register reads/writes for the
// system-bus arbiter. Write and read channels run independently; completion
// is signalled by the channel's *_master_ready returning high.
// Ports:
//   clk_in, areset                          : clock, synchronous active-high reset
//   sys_write_req/addr/data, sys_write_master_ready : write request side
//   sys_read_req/addr, sys_read_data(_valid), sys_read_master_ready : read side
//   m_axi_*                                 : AXI4-Lite master bus
// Optional: define AXIL_MASTER_ERR_CAPTURE_EN to add err_flag / err_addr /
// err_resp, which record the first non-OKAY response seen.
// -----------------------------------------------------------------------------
module axil_reg_master
  import axil_master_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk_in,
  input  logic              areset,
  input  logic              sys_write_req,
  input  logic [63:0]       sys_write_addr,
  input  logic [31:0]       sys_write_data,
  output logic              sys_write_master_ready,
  input  logic              sys_read_req,
  input  logic [63:0]       sys_read_addr,
  output logic [31:0]       sys_read_data,
  output logic              sys_read_data_valid,
  output logic              sys_read_master_ready,
`ifdef AXIL_MASTER_ERR_CAPTURE_EN
  output logic              err_flag,
  output logic [ADDR_W-1:0] err_addr,
  output logic [1:0]        err_resp,
`endif
  output logic [ADDR_W-1:0] m_axi_awaddr,
  output logic [2:0]        m_axi_awprot,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  output logic [31:0]       m_axi_wdata,
  output logic [3:0]        m_axi_wstrb,
  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,
  input  logic [1:0]        m_axi_bresp,
  input  logic              m_axi_bvalid,
  output logic              m_axi_bready,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic [2:0]        m_axi_arprot,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [31:0]       m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready
);

  assign m_axi_awprot = PROT_DEFAULT;
  assign m_axi_arprot = PROT_DEFAULT;
  assign m_axi_wstrb  = WSTRB_ALL;

  // Upper address bits are dropped by design; response codes only matter
  // when error capture is built in.
  logic unused_ok;
  assign unused_ok = ^{sys_write_addr, sys_read_addr, m_axi_bresp, m_axi_rresp};

  axil_master_wr #(
    .ADDR_W(ADDR_W)
  ) u_wr (
    .clk_in       (clk_in),
    .areset       (areset),
    .req          (sys_write_req),
    .addr         (sys_write_addr[ADDR_W-1:0]),
    .data         (sys_write_data),
    .ready        (sys_write_master_ready),
    .m_axi_awaddr (m_axi_awaddr),
    .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready),
    .m_axi_wdata  (m_axi_wdata),
    .m_axi_wvalid (m_axi_wvalid),
    .m_axi_wready (m_axi_wready),
    .m_axi_bvalid (m_axi_bvalid),
    .m_axi_bready (m_axi_bready)
  );

  rd_state_t rd_state;

  always_ff @(posedge clk_in) begin
    if (areset) begin
      rd_state              <= R_IDLE;
      sys_read_master_ready <= 1'b1;
      sys_read_data         <= '0;
      sys_read_data_valid   <= 1'b0;
      m_axi_araddr          <= '0;
      m_axi_arvalid         <= 1'b0;
      m_axi_rready          <= 1'b0;
    end else begin
      sys_read_data_valid <= 1'b0;
      case (rd_state)
        R_IDLE: begin
          if (sys_read_req) begin
            m_axi_araddr          <= sys_read_addr[ADDR_W-1:0];
            m_axi_arvalid         <= 1'b1;
            sys_read_master_ready <= 1'b0;
            rd_state              <= R_ADDR;
          end
        end
        R_ADDR: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            rd_state      <= R_DATA;
          end
        end
        R_DATA: begin
          if (m_axi_rvalid) begin
            m_axi_rready          <= 1'b0;
            sys_read_data         <= m_axi_rdata;
            sys_read_data_valid   <= 1'b1;
            sys_read_master_ready <= 1'b1;
            rd_state              <= R_IDLE;
          end
        end
        default: begin
          rd_state <= R_IDLE;
        end
      endcase
    end
  end

`ifdef AXIL_MASTER_ERR_CAPTURE_EN
  // The latched AW/AR addresses stay put until the next request, so they
  // still identify the transaction when its response arrives.
  logic wr_err, rd_err;
  assign wr_err = m_axi_bvalid && m_axi_bready && resp_is_err(m_axi_bresp);
  assign rd_err = m_axi_rvalid && m_axi_rready && resp_is_err(m_axi_rresp);

  always_ff @(posedge clk_in) begin
    if (areset) begin
      err_flag <= 1'b0;
      err_addr <= '0;
      err_resp <= RESP_OKAY;
    end else if (!err_flag) begin
      // Write error wins when both channels fail in the same cycle.
      if (wr_err) begin
        err_flag <= 1'b1;
        err_addr <= m_axi_awaddr;
        err_resp <= m_axi_bresp;
      end else if (rd_err) begin
        err_flag <= 1'b1;
        err_addr <= m_axi_araddr;
        err_resp <= m_axi_rresp;
      end
    end
  end
`endif

endmodule

// File: tb/tb_axil_reg_master.sv
// -----------------------------------------------------------------------------
// tb_axil_reg_master
// Directed scenarios with literal expectations followed by a randomized run.
// The slave is driven from the bench's own transaction model, and every cycle
// all DUT outputs are compared against that model.
// -----------------------------------------------------------------------------
module tb_axil_reg_master;

  logic        clk_in;
  logic        areset;
  logic        sys_write_req;
  logic [63:0] sys_write_addr;
  logic [31:0] sys_write_data;
  logic        sys_write_master_ready;
  logic        sys_read_req;
  logic [63:0] sys_read_addr;
  logic [31:0] sys_read_data;
  logic        sys_read_data_valid;
  logic        sys_read_master_ready;
`ifdef AXIL_MASTER_ERR_CAPTURE_EN
  logic        err_flag;
  logic [31:0] err_addr;
  logic [1:0]  err_resp;
`endif
  logic [31:0] m_axi_awaddr;
  logic [2:0]  m_axi_awprot;
  logic        m_axi_awvalid;
  logic        m_axi_awready;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wvalid;
  logic        m_axi_wready;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_bvalid;
  logic        m_axi_bready;
  logic [31:0] m_axi_araddr;
  logic [2:0]  m_axi_arprot;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rvalid;
  logic        m_axi_rready;

  axil_reg_master #(.ADDR_W(32)) dut (
    .clk_in                (clk_in),
    .areset                (areset),
    .sys_write_req         (sys_write_req),
    .sys_write_addr        (sys_write_addr),
    .sys_write_data        (sys_write_data),
    .sys_write_master_ready(sys_write_master_ready),
    .sys_read_req          (sys_read_req),
    .sys_read_addr         (sys_read_addr),
    .sys_read_data         (sys_read_data),
    .sys_read_data_valid   (sys_read_data_valid),
    .sys_read_master_ready (sys_read_master_ready),
`ifdef AXIL_MASTER_ERR_CAPTURE_EN
    .err_flag              (err_flag),
    .err_addr              (err_addr),
    .err_resp              (err_resp),
`endif
    .m_axi_awaddr          (m_axi_awaddr),
    .m_axi_awprot          (m_axi_awprot),
    .m_axi_awvalid         (m_axi_awvalid),
    .m_axi_awready         (m_axi_awready),
    .m_axi_wdata           (m_axi_wdata),
    .m_axi_wstrb           (m_axi_wstrb),
    .m_axi_wvalid          (m_axi_wvalid),
    .m_axi_wready          (m_axi_wready),
    .m_axi_bresp           (m_axi_bresp),
    .m_axi_bvalid          (m_axi_bvalid),
    .m_axi_bready          (m_axi_bready),
    .m_axi_araddr          (m_axi_araddr),
    .m_axi_arprot          (m_axi_arprot),
    .m_axi_arvalid         (m_axi_arvalid),
    .m_axi_arready         (m_axi_arready),
    .m_axi_rdata           (m_axi_rdata),
    .m_axi_rresp           (m_axi_rresp),
    .m_axi_rvalid          (m_axi_rvalid),
    .m_axi_rready          (m_axi_rready)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int n_chk  = 0;
  int n_fail = 0;

  // Transaction-level model: what the master owes on each channel.
  bit          exp_wr_busy, exp_aw_pend, exp_w_pend, exp_b_phase;
  bit          exp_rd_busy, exp_ar_pend, exp_r_phase, exp_rd_pulse;
  logic [31:0] exp_awaddr, exp_wdata, exp_araddr, exp_rdata;
  bit          exp_err_flag;
  logic [31:0] exp_err_addr;
  logic [1:0]  exp_err_resp;

  // Slave behaviour knobs.
  bit rand_mode = 0;
  bit hold_aw = 0, hold_w = 0, hold_b = 0, hold_ar = 0, hold_r = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic slave_drive();
    if (rand_mode) begin
      m_axi_awready = 1'($urandom_range(0, 1));
      m_axi_wready  = 1'($urandom_range(0, 1));
      m_axi_arready = 1'($urandom_range(0, 1));
      m_axi_bvalid  = exp_b_phase && ($urandom_range(0, 2) != 0);
      m_axi_rvalid  = exp_r_phase && ($urandom_range(0, 2) != 0);
      m_axi_bresp   = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      m_axi_rresp   = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      m_axi_rdata   = $urandom;
    end else begin
      m_axi_awready = !hold_aw;
      m_axi_wready  = !hold_w;
      m_axi_arready = !hold_ar;
      m_axi_bvalid  = exp_b_phase && !hold_b;
      m_axi_rvalid  = exp_r_phase && !hold_r;
    end
  endtask

  // Advance the model across one clock edge using what the bench drove.
  task automatic model_update();
    bit b_hs, r_hs;
    b_hs = exp_b_phase && m_axi_bvalid;
    r_hs = exp_r_phase && m_axi_rvalid;
    exp_rd_pulse = 0;
    if (areset) begin
      exp_wr_busy = 0; exp_aw_pend = 0; exp_w_pend = 0; exp_b_phase = 0;
      exp_rd_busy = 0; exp_ar_pend = 0; exp_r_phase = 0;
      exp_awaddr = '0; exp_wdata = '0; exp_araddr = '0; exp_rdata = '0;
      exp_err_flag = 0; exp_err_addr = '0; exp_err_resp = 2'b00;
    end else begin
      if (!exp_err_flag) begin
        if (b_hs && m_axi_bresp != 2'b00) begin
          exp_err_flag = 1; exp_err_addr = exp_awaddr; exp_err_resp = m_axi_bresp;
        end else if (r_hs && m_axi_rresp != 2'b00) begin
          exp_err_flag = 1; exp_err_addr = exp_araddr; exp_err_resp = m_axi_rresp;
        end
      end
      if (!exp_wr_busy) begin
        if (sys_write_req) begin
          exp_wr_busy = 1; exp_aw_pend = 1; exp_w_pend = 1;
          exp_awaddr = sys_write_addr[31:0]; exp_wdata = sys_write_data;
        end
      end else if (exp_b_phase) begin
        if (b_hs) begin exp_b_phase = 0; exp_wr_busy = 0; end
      end else begin
        if (m_axi_awready) exp_aw_pend = 0;
        if (m_axi_wready)  exp_w_pend  = 0;
        if (!exp_aw_pend && !exp_w_pend) exp_b_phase = 1;
      end
      if (!exp_rd_busy) begin
        if (sys_read_req) begin
          exp_rd_busy = 1; exp_ar_pend = 1; exp_araddr = sys_read_addr[31:0];
        end
      end else if (exp_ar_pend) begin
        if (m_axi_arready) begin exp_ar_pend = 0; exp_r_phase = 1; end
      end else if (r_hs) begin
        exp_r_phase = 0; exp_rd_busy = 0; exp_rdata = m_axi_rdata; exp_rd_pulse = 1;
      end
    end
  endtask

  task automatic compare_all();
    chk("wr_ready",  sys_write_master_ready, !exp_wr_busy);
    chk("rd_ready",  sys_read_master_ready,  !exp_rd_busy);
    chk("rd_data",   sys_read_data,          exp_rdata);
    chk("rd_valid",  sys_read_data_valid,    exp_rd_pulse);
    chk("awaddr",    m_axi_awaddr,           exp_awaddr);
    chk("awprot",    m_axi_awprot,           3'b000);
    chk("awvalid",   m_axi_awvalid,          exp_aw_pend);
    chk("wdata",     m_axi_wdata,            exp_wdata);
    chk("wstrb",     m_axi_wstrb,            4'hF);
    chk("wvalid",    m_axi_wvalid,           exp_w_pend);
    chk("bready",    m_axi_bready,           exp_b_phase);
    chk("araddr",    m_axi_araddr,           exp_araddr);
    chk("arprot",    m_axi_arprot,           3'b000);
    chk("arvalid",   m_axi_arvalid,          exp_ar_pend);
    chk("rready",    m_axi_rready,           exp_r_phase);
`ifdef AXIL_MASTER_ERR_CAPTURE_EN
    chk("err_flag",  err_flag,               exp_err_flag);
    chk("err_addr",  err_addr,               exp_err_addr);
    chk("err_resp",  err_resp,               exp_err_resp);
`endif
  endtask

  // Drive one cycle's inputs, cross the edge, then check at the falling edge.
  task automatic tick();
    slave_drive();
    @(posedge clk_in);
    model_update();
    @(negedge clk_in);
    compare_all();
    sys_write_req = 1'b0;
    sys_read_req  = 1'b0;
  endtask

  initial begin
    areset = 1'b1;
    sys_write_req = 0; sys_write_addr = '0; sys_write_data = '0;
    sys_read_req = 0;  sys_read_addr = '0;
    m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
    m_axi_bvalid = 0;  m_axi_bresp = 2'b00;
    m_axi_rvalid = 0;  m_axi_rresp = 2'b00; m_axi_rdata = '0;
    tick();
    tick();
    chk("lit_rst_wr_ready", sys_write_master_ready, 1);
    chk("lit_rst_rd_ready", sys_read_master_ready, 1);
    chk("lit_rst_awvalid",  m_axi_awvalid, 0);
    chk("lit_rst_rd_data",  sys_read_data, 0);
    areset = 1'b0;
    tick();

    // Zero-wait write 0x1000 <- 5.
    sys_write_req = 1; sys_write_addr = 64'h1000; sys_write_data = 32'h5;
    tick();
    chk("lit_w_awvalid", m_axi_awvalid, 1);
    chk("lit_w_wvalid",  m_axi_wvalid, 1);
    chk("lit_w_awaddr",  m_axi_awaddr, 32'h1000);
    chk("lit_w_wdata",   m_axi_wdata, 32'h5);
    chk("lit_w_wstrb",   m_axi_wstrb, 4'hF);
    chk("lit_w_busy",    sys_write_master_ready, 0);
    tick();
    chk("lit_w_bready",  m_axi_bready, 1);
    chk("lit_w_aw_drop", m_axi_awvalid, 0);
    tick();
    chk("lit_w_done",    sys_write_master_ready, 1);
    chk("lit_w_bready0", m_axi_bready, 0);

    // Read 0x1C, three wait cycles on R, data DEADBEEF.
    hold_r = 1; m_axi_rdata = 32'hDEAD_BEEF; m_axi_rresp = 2'b00;
    sys_read_req = 1; sys_read_addr = 64'h1C;
    tick();
    chk("lit_r_arvalid", m_axi_arvalid, 1);
    chk("lit_r_araddr",  m_axi_araddr, 32'h1C);
    tick();
    chk("lit_r_rready",  m_axi_rready, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("lit_r_wait_valid", sys_read_data_valid, 0);
      chk("lit_r_wait_ready", sys_read_master_ready, 0);
    end
    hold_r = 0;
    tick();
    chk("lit_r_valid",  sys_read_data_valid, 1);
    chk("lit_r_data",   sys_read_data, 32'hDEAD_BEEF);
    chk("lit_r_ready",  sys_read_master_ready, 1);
    tick();
    chk("lit_r_pulse_end", sys_read_data_valid, 0);
    chk("lit_r_data_hold", sys_read_data, 32'hDEAD_BEEF);

    // awready immediately, wready only in the fourth valid cycle.
    hold_w = 1;
    sys_write_req = 1; sys_write_addr = 64'h2000; sys_write_data = 32'hA5A5;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("lit_skew_awvalid", m_axi_awvalid, 0);
      chk("lit_skew_wvalid",  m_axi_wvalid, 1);
      chk("lit_skew_bready",  m_axi_bready, 0);
    end
    hold_w = 0;
    tick();
    chk("lit_skew_wdrop",  m_axi_wvalid, 0);
    chk("lit_skew_bready", m_axi_bready, 1);
    tick();
    chk("lit_skew_done",   sys_write_master_ready, 1);

    // Concurrent write + read, with an extra write pulse while busy.
    m_axi_rdata = 32'h1234_5678;
    sys_write_req = 1; sys_write_addr = 64'h3000; sys_write_data = 32'h33;
    sys_read_req  = 1; sys_read_addr  = 64'hFFFF_0000_0000_4000;
    tick();
    chk("lit_cc_awvalid", m_axi_awvalid, 1);
    chk("lit_cc_arvalid", m_axi_arvalid, 1);
    chk("lit_cc_araddr",  m_axi_araddr, 32'h4000);
    sys_write_req = 1; sys_write_addr = 64'h5000; sys_write_data = 32'h55;
    tick();
    tick();
    chk("lit_cc_wr_done", sys_write_master_ready, 1);
    chk("lit_cc_rd_done", sys_read_master_ready, 1);
    chk("lit_cc_rdata",   sys_read_data, 32'h1234_5678);
    chk("lit_cc_awaddr",  m_axi_awaddr, 32'h3000);
    tick();
    chk("lit_cc_no_extra", m_axi_awvalid, 0);

    // Reset while bready is high.
    hold_b = 1;
    sys_write_req = 1; sys_write_addr = 64'h6000; sys_write_data = 32'h66;
    tick();
    tick();
    chk("lit_rm_bready", m_axi_bready, 1);
    areset = 1;
    tick();
    chk("lit_rm_bready0",   m_axi_bready, 0);
    chk("lit_rm_awvalid",   m_axi_awvalid, 0);
    chk("lit_rm_wvalid",    m_axi_wvalid, 0);
    chk("lit_rm_wr_ready",  sys_write_master_ready, 1);
    chk("lit_rm_rd_ready",  sys_read_master_ready, 1);
    areset = 0; hold_b = 0;
    tick();

`ifdef AXIL_MASTER_ERR_CAPTURE_EN
    m_axi_bresp = 2'b10;
    sys_write_req = 1; sys_write_addr = 64'h1004; sys_write_data = 32'h7;
    tick(); tick(); tick();
    m_axi_bresp = 2'b00;
    chk("lit_err_flag", err_flag, 1);
    chk("lit_err_addr", err_addr, 32'h1004);
    chk("lit_err_resp", err_resp, 2'b10);
    m_axi_rresp = 2'b11;
    sys_read_req = 1; sys_read_addr = 64'h2008;
    tick(); tick(); tick();
    m_axi_rresp = 2'b00;
    chk("lit_err_flag_hold", err_flag, 1);
    chk("lit_err_addr_hold", err_addr, 32'h1004);
    chk("lit_err_resp_hold", err_resp, 2'b10);
`endif

    // Randomized traffic with occasional reset.
    rand_mode = 1;
    for (int i = 0; i < 3000; i++) begin
      areset         = ($urandom_range(0, 299) == 0);
      sys_write_req  = ($urandom_range(0, 2) == 0);
      sys_write_addr = {$urandom, $urandom};
      sys_write_data = $urandom;
      sys_read_req   = ($urandom_range(0, 2) == 0);
      sys_read_addr  = {$urandom, $urandom};
      tick();
    end
    areset = 0;

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/axil_reg_master.md
# axil_reg_master

Single-beat AXI4-Lite master that executes the register read and write transactions issued by the system-bus arbiter. It accepts one-cycle `sys_write_req` / `sys_read_req` pulses with address and data, performs them on an AXI4-Lite bus toward the NVMe controller BAR, and returns read data. It signals completion by raising `sys_write_master_ready` / `sys_read_master_ready` again; the arbiter detects this rising edge as "done". The write and read channels are fully independent and may be in flight at the same time.

## Interface
- `ADDR_W`, 32: AXI address width; the low `ADDR_W` bits of the 64-bit request address are used.
- `clk_in`  in  1  single clock for all logic.
- `areset`  in  1  reset, synchronous, active-high.
- `sys_write_req`  in  1  one-cycle write request pulse.
- `sys_write_addr`  in  64  write address, sampled with the request.
- `sys_write_data`  in  32  write data, sampled with the request.
- `sys_write_master_ready`  out  1  high = write channel idle.
- `sys_read_req`  in  1  one-cycle read request pulse.
- `sys_read_addr`  in  64  read address, sampled with the request.
- `sys_read_data`  out  32  registered read data.
- `sys_read_data_valid`  out  1  one-cycle pulse; `sys_read_data` is valid.
- `sys_read_master_ready`  out  1  high = read channel idle.
- AXI4-Lite master channels:
  - `m_axi_awaddr`  out  `ADDR_W`
  - `m_axi_awprot`  out  3
  - `m_axi_awvalid`  out  1
  - `m_axi_awready`  in  1
  - `m_axi_wdata`  out  32
  - `m_axi_wstrb`  out  4
  - `m_axi_wvalid`  out  1
  - `m_axi_wready`  in  1
  - `m_axi_bresp`  in  2
  - `m_axi_bvalid`  in  1
  - `m_axi_bready`  out  1
  - `m_axi_araddr`  out  `ADDR_W`
  - `m_axi_arprot`  out  3
  - `m_axi_arvalid`  out  1
  - `m_axi_arready`  in  1
  - `m_axi_rdata`  in  32
  - `m_axi_rresp`  in  2
  - `m_axi_rvalid`  in  1
  - `m_axi_rready`  out  1

## Operation
- **Write FSM states:**
  - W_IDLE: on `sys_write_req`, latch the address and data, go to W_ADDR.
  - W_ADDR: `awvalid` and `wvalid` are asserted together. Each one drops independently on its own handshake. Go to W_RESP once both handshakes have completed (same or different cycles).
  - W_RESP: `bready` is high. On `bvalid`, go to W_IDLE.
- **Read FSM states:**
  - R_IDLE: on `sys_read_req`, latch the address, go to R_ADDR.
  - R_ADDR: `arvalid` high until `arready`, then go to R_DATA.
  - R_DATA: `rready` high. On `rvalid`, latch `rdata`, go to R_IDLE.
- `sys_*_master_ready` equals (state == *_IDLE).
- A request pulse that arrives while the channel is not idle is ignored; no queuing.
- Fixed outputs: `wstrb` = 4'hF, `awprot` = `arprot` = 3'b000.
- Non-OKAY BRESP/RRESP: the transaction still completes normally. Read data is passed through unchanged.
- Address width rule: the address is the 64-bit input truncated to its low `ADDR_W` bits, with no alignment check.
- Simultaneous write and read requests: both are accepted in the same cycle and proceed concurrently.
- **Reset values:** both FSMs idle, both ready = 1, all valid/ready outputs 0, `sys_read_data` = 0, `sys_read_data_valid` = 0, latched address and data = 0.
- **Reset mid-transaction:** all AXI valids drop on the reset edge and the transaction is abandoned. The bench's slave must also be reset.

## Timing
- All outputs are registered.
- Request sampled at edge N → ready low and `awvalid`/`wvalid` (or `arvalid`) high from N+1.
- Zero-wait slave, write: AW/W handshake at N+1, `bready` high at N+2, B handshake at N+2, ready high at N+3.
- Zero-wait slave, read: AR handshake at N+1, R handshake at N+2. `sys_read_data_valid` pulses at N+3, in the same cycle that `sys_read_master_ready` rises; `sys_read_data` then holds until the next R handshake.
- AXI valids never drop before their handshake. Address and data stay stable while valid is high.
- Back-to-back: a new request is accepted in the first cycle that ready is high.

## Configuration
- `AXIL_MASTER_ERR_CAPTURE_EN` defined adds three outputs:
  - `err_flag` (1): sticky; set on any BRESP/RRESP ≠ 2'b00.
  - `err_addr` (`ADDR_W`): address of the first failing transaction.
  - `err_resp` (2): response code of the first failing transaction.
- `err_flag` is cleared only by `areset`. `err_addr` and `err_resp` are captured only while `err_flag` = 0.
- If BRESP and RRESP errors occur in the same cycle, the write error is captured.
- Without the macro these ports do not exist and response codes are ignored.

## Structure
- Shared package `axil_master_pkg`:
  - write and read FSM state enums
  - response constants: OKAY 2'b00, EXOKAY 2'b01, SLVERR 2'b10, DECERR 2'b11
  - the default `wstrb`/`prot` constants
- One natural sub-module: `axil_master_wr`, the write FSM with its AW/W/B channels. The read FSM stays in the top module.

## Test plan
- Zero-wait slave, write addr 0x1000, data 0x0000_0005 → AW/W at N+1, awaddr 0x1000, wdata 5, wstrb F; ready rises at N+3.
- Read addr 0x1C, slave returns 0xDEAD_BEEF after 3 wait cycles on R → `sys_read_data_valid` pulses once with 0xDEAD_BEEF, coincident with ready rising.
- `awready` at cycle 1 and `wready` at cycle 4 after valid → `awvalid` drops after 1 cycle, `wvalid` holds until its handshake; `bready` is asserted only after both handshakes.
- Write and read requested in the same cycle, plus a second write pulse while busy → both transactions complete; the second write pulse produces no AXI activity.
- Reset asserted while `bready` is high → the next cycle shows all valids/readies 0 and both ready = 1.
- With `AXIL_MASTER_ERR_CAPTURE_EN`: BRESP 2'b10 at addr 0x1004, then RRESP 2'b11 → `err_flag` = 1, `err_addr` = 0x1004, `err_resp` = 2'b10, both held.
